// File: rtl/cbs_pkg.sv
// -----------------------------------------------------------------------------
// cbs_pkg
// Shared constants and types for the CBS 3x3 convolution tile scheduler.
//   PIX_W    : pixel / tap width
//   TAPS     : number of filter taps (3x3)
//   WIN_COLS : pixels per window row (8 outputs + 2 halo)
//   WIN_ROWS : rows per window
//   LANES    : output lanes per tile (tile stride)
//   RES_W    : width of one engine result (8 lanes x 15 bits)
// -----------------------------------------------------------------------------
package cbs_pkg;

  localparam int PIX_W    = 8;
  localparam int TAPS     = 9;
  localparam int WIN_COLS = 10;
  localparam int WIN_ROWS = 3;
  localparam int LANES    = 8;
  localparam int RES_W    = 120;

  localparam int FILT_W   = PIX_W * TAPS;
  localparam int ROWSL_W  = PIX_W * WIN_COLS;
  localparam int WIN_W    = ROWSL_W * WIN_ROWS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // Advance a line-buffer slot pointer around the ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ring3_inc(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cbs_line_buf3.sv
// -----------------------------------------------------------------------------
// cbs_line_buf3
// Three rotating IMG_W x 8-bit line buffers plus the 3-row x 10-pixel window
// read mux feeding the CBS engine.
//   clk, rst   : clock, asynchronous active-high reset (pointer only)
//   clr_i      : return the write pointer to slot 0 (frame start)
//   wr_en_i    : write wr_pix_i into slot wptr at column wr_col_i
//   wr_last_i  : current write is the last pixel of a row -> rotate pointer
//   tile_i     : tile index; window covers pixels 8*tile .. 8*tile+9
//   win_o      : [239:160] oldest row, [159:80] middle, [79:0] newest,
//                leftmost pixel in the MSB byte of each row slice
// -----------------------------------------------------------------------------
module cbs_line_buf3
  import cbs_pkg::*;
#(
  parameter int IMG_W  = 34,
  parameter int COL_W  = 6,
  parameter int TILE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [COL_W-1:0]  wr_col_i,
  input  logic [PIX_W-1:0]  wr_pix_i,
  input  logic              wr_last_i,
  input  logic [TILE_W-1:0] tile_i,
  output logic [WIN_W-1:0]  win_o
);

  logic [PIX_W-1:0] mem_q [3][IMG_W];
  logic [1:0]       wptr_q;
  logic [1:0]       slot_s [3];

  // Pixel storage; contents are meaningless until rows are loaded, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wptr_q][wr_col_i] <= wr_pix_i;
    end
  end

  // Write pointer: after a row completes it points at the oldest row,
  // which is exactly the slot the next incoming row must overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= 2'd0;
    end else if (clr_i) begin
      wptr_q <= 2'd0;
    end else if (wr_en_i && wr_last_i) begin
      wptr_q <= ring3_inc(wptr_q);
    end
  end

  // Window mux: slots ordered oldest (wptr), middle, newest.
  always_comb begin
    slot_s[0] = wptr_q;
    slot_s[1] = ring3_inc(wptr_q);
    slot_s[2] = ring3_inc(ring3_inc(wptr_q));
    win_o     = '0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      for (int k = 0; k < WIN_COLS; k++) begin
        win_o[WIN_W-1 - r*ROWSL_W - k*PIX_W -: PIX_W] =
          mem_q[slot_s[r]][COL_W'(LANES * int'(tile_i) + k)];
      end
    end
  end

endmodule

// File: rtl/cbs_tile_scheduler.sv
// -----------------------------------------------------------------------------
// cbs_tile_scheduler
// Streams raster pixels into three rotating line buffers and, once three rows
// are held, issues one 3x10 window per tile (stride 8) to the CBS engine,
// registering each 120-bit result with a row/tile tag under valid/ready.
//   start / cfg_filter_we / cfg_filter : frame start and filter load (IDLE only)
//   in_valid / in_ready / in_pixel     : raster pixel input
//   win_img / win_filter / conv_result : combinational engine interface
//   res_valid / res_ready / res_data / res_row / res_tile / res_last : results
//   busy, frame_done                   : status
// Optional build macro CBS_SCHED_PERF_EN adds stall_cycles and in_stall_cycles
// saturating 32-bit counters.
// -----------------------------------------------------------------------------
module cbs_tile_scheduler
  import cbs_pkg::*;
#(
  parameter  int IMG_W  = 34,
  parameter  int IMG_H  = 34,
  localparam int NT     = (IMG_W - 2) / 8,
  localparam int ROW_W  = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1,
  localparam int TILE_W = ($clog2(NT) > 1) ? $clog2(NT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_filter_we,
  input  logic [71:0]       cfg_filter,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_pixel,
  output logic [239:0]      win_img,
  output logic [71:0]       win_filter,
  input  logic [119:0]      conv_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [119:0]      res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic [TILE_W-1:0] res_tile,
  output logic              res_last,
  output logic              busy,
  output logic              frame_done
`ifdef CBS_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       in_stall_cycles
`endif
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROWC_W = $clog2(IMG_H + 1);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 3);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NT - 1);

  sched_state_t      state_q;
  logic [FILT_W-1:0] filter_q;
  logic [COL_W-1:0]  col_q;
  logic [ROWC_W-1:0] row_q;       // rows loaded so far this frame
  logic [ROW_W-1:0]  out_row_q;
  logic [TILE_W-1:0] tile_q;
  logic              res_valid_q;
  logic [RES_W-1:0]  res_data_q;
  logic [ROW_W-1:0]  res_row_q;
  logic [TILE_W-1:0] res_tile_q;
  logic              res_last_q;
  logic              frame_done_q;

  logic              pix_acc_s;
  logic              issue_s;
  logic              start_acc_s;

  assign in_ready    = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  assign pix_acc_s   = in_valid && (state_q == FILL);
  assign start_acc_s = start && (state_q == IDLE);
  // Output register is free when empty or being drained this cycle.
  assign issue_s     = (state_q == EMIT) && (!res_valid_q || res_ready);

  assign win_filter  = filter_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_row     = res_row_q;
  assign res_tile    = res_tile_q;
  assign res_last    = res_last_q;
  assign frame_done  = frame_done_q;

  cbs_line_buf3 #(
    .IMG_W  (IMG_W),
    .COL_W  (COL_W),
    .TILE_W (TILE_W)
  ) u_lbuf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_acc_s),
    .wr_en_i   (pix_acc_s),
    .wr_col_i  (col_q),
    .wr_pix_i  (in_pixel),
    .wr_last_i (col_q == COL_LAST),
    .tile_i    (tile_q),
    .win_o     (win_img)
  );

  // Scheduler FSM with counters and the registered result stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      filter_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      out_row_q    <= '0;
      tile_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_row_q    <= '0;
      res_tile_q   <= '0;
      res_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // A new issue replaces the held result even while it is being drained.
      if (issue_s) begin
        res_valid_q <= 1'b1;
        res_data_q  <= conv_result;
        res_row_q   <= out_row_q;
        res_tile_q  <= tile_q;
        res_last_q  <= (out_row_q == ROW_LAST) && (tile_q == TILE_LAST);
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cfg_filter_we) begin
            filter_q <= cfg_filter;
          end
          if (start) begin
            state_q   <= FILL;
            col_q     <= '0;
            row_q     <= '0;
            out_row_q <= '0;
            tile_q    <= '0;
          end
        end
        FILL: begin
          if (pix_acc_s) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + ROWC_W'(1);
              // Third row (or any later refill row) completes the window set.
              if (row_q >= ROWC_W'(2)) begin
                state_q <= EMIT;
                tile_q  <= '0;
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        EMIT: begin
          if (issue_s) begin
            if (tile_q == TILE_LAST) begin
              tile_q <= '0;
              if (out_row_q == ROW_LAST) begin
                state_q <= DONE;
              end else begin
                out_row_q <= out_row_q + ROW_W'(1);
                state_q   <= FILL;
              end
            end else begin
              tile_q <= tile_q + TILE_W'(1);
            end
          end
        end
        DONE: begin
          if (!res_valid_q) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CBS_SCHED_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] in_stall_q;

  assign stall_cycles    = stall_q;
  assign in_stall_cycles = in_stall_q;

  // Saturating stall counters, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q    <= 32'd0;
      in_stall_q <= 32'd0;
    end else if (start_acc_s) begin
      stall_q    <= 32'd0;
      in_stall_q <= 32'd0;
    end else begin
      if (res_valid_q && !res_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (in_valid && !in_ready && busy && (in_stall_q != 32'hFFFF_FFFF)) begin
        in_stall_q <= in_stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cbs_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cbs_tile_scheduler
// Self-checking bench for cbs_tile_scheduler (IMG_W=18, IMG_H=4).
// A behavioural CBS engine drives conv_result from win_img/win_filter; the
// expected results are computed directly from the image and filter arrays.
// -----------------------------------------------------------------------------
module tb_cbs_tile_scheduler;

  localparam int W    = 18;
  localparam int H    = 4;
  localparam int NT   = (W - 2) / 8;
  localparam int NRES = (H - 2) * NT;

  logic         clk;
  logic         rst;
  logic         start;
  logic         cfg_filter_we;
  logic [71:0]  cfg_filter;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_pixel;
  logic [239:0] win_img;
  logic [71:0]  win_filter;
  logic [119:0] conv_result;
  logic         res_valid;
  logic         res_ready;
  logic [119:0] res_data;
  logic [1:0]   res_row;
  logic [0:0]   res_tile;
  logic         res_last;
  logic         busy;
  logic         frame_done;
`ifdef CBS_SCHED_PERF_EN
  logic [31:0]  stall_cycles;
  logic [31:0]  in_stall_cycles;
`endif

  int n_checks;
  int n_errors;

  logic [7:0] pix  [W*H];
  logic [7:0] taps [9];

  typedef struct {
    int row;
    int tile;
    bit last;
    int lane0;
    int lane7;
  } vec_t;

  typedef struct {
    int vm;      // 0 always valid, 1 every other cycle, 2 random
    int rm;      // 0 always ready, 1 stall first result 5 cycles, 2 random, 3 never
    bit inject;  // mid-frame filter write and start pulse
  } scen_t;

  vec_t  basic_tab [NRES];
  scen_t scen_tab  [5];

  cbs_tile_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_filter_we (cfg_filter_we),
    .cfg_filter    (cfg_filter),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pixel      (in_pixel),
    .win_img       (win_img),
    .win_filter    (win_filter),
    .conv_result   (conv_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_row       (res_row),
    .res_tile      (res_tile),
    .res_last      (res_last),
    .busy          (busy),
    .frame_done    (frame_done)
`ifdef CBS_SCHED_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .in_stall_cycles (in_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CBS engine: lane k = sum of tap(r,c) * window(r, k+c), 15 bits.
  always_comb begin : engine_model
    int acc;
    acc         = 0;
    conv_result = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          acc += int'(win_filter[71 - 8*(r*3+c) -: 8]) * int'(win_img[239 - 80*r - 8*(k+c) -: 8]);
        end
      end
      conv_result[119 - 15*k -: 15] = acc[14:0];
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [71:0] pack_taps();
    logic [71:0] f;
    for (int t = 0; t < 9; t++) f[71 - 8*t -: 8] = taps[t];
    return f;
  endfunction

  // Reference: convolution over the image itself, no window bookkeeping.
  function automatic logic [119:0] exp_res(input int row, input int tile);
    logic [119:0] v;
    int acc;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          acc += int'(taps[r*3+c]) * int'(pix[(row + r) * W + 8*tile + k + c]);
      v[119 - 15*k -: 15] = 15'(acc % 32768);
    end
    return v;
  endfunction

  task automatic load_filter();
    @(negedge clk);
    cfg_filter_we = 1'b1;
    cfg_filter    = pack_taps();
    @(negedge clk);
    cfg_filter_we = 1'b0;
    chk("win_filter_load", win_filter, pack_taps());
  endtask

  task automatic run_frame(input int vm, input int rm, input bit inject, input bit use_tab, input bit abort);
    int acc_cnt, nacc, nseen, stall_left, done_cnt, hold_cnt;
    bit prev_valid, prev_taken, new_res;
    logic [119:0] held;
    acc_cnt = 0; nacc = 0; nseen = 0; stall_left = 5; done_cnt = 0; hold_cnt = 0;
    prev_valid = 1'b0; prev_taken = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      case (rm)
        0: res_ready = 1'b1;
        1: begin
          if (res_valid && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
          end else begin
            res_ready = 1'b1;
          end
        end
        2: res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
      if (inject && cyc == 40) begin
        chk("busy_mid_frame", busy, 1'b1);
        cfg_filter_we = 1'b1;
        cfg_filter    = {72{1'b1}};
        start         = 1'b1;
      end else begin
        cfg_filter_we = 1'b0;
        start         = 1'b0;
      end
      if (acc_cnt < W*H) begin
        case (vm)
          0: in_valid = 1'b1;
          1: in_valid = (cyc % 2 == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        in_valid = 1'b0;
      end
      in_pixel = (in_valid && acc_cnt < W*H) ? pix[acc_cnt] : 8'($urandom);

      if (res_valid) begin
        new_res = !prev_valid || prev_taken;
        if (new_res) begin
          // Input must stall during EMIT: exactly (row+3) rows consumed per issue.
          if (nseen < NRES) chk("pixels_before_issue", acc_cnt, ((nseen / NT) + 3) * W);
          held = res_data;
          nseen++;
        end else begin
          chk("res_data_hold", res_data, held);
        end
        if (res_ready) begin
          if (nacc < NRES) begin
            chk("res_row", res_row, nacc / NT);
            chk("res_tile", res_tile, nacc % NT);
            chk("res_last", res_last, (nacc == NRES - 1));
            chk("res_data", res_data, exp_res(nacc / NT, nacc % NT));
            if (use_tab) begin
              chk("tab_row", res_row, basic_tab[nacc].row);
              chk("tab_tile", res_tile, basic_tab[nacc].tile);
              chk("tab_last", res_last, basic_tab[nacc].last);
              chk("tab_lane0", res_data[119:105], basic_tab[nacc].lane0);
              chk("tab_lane7", res_data[14:0], basic_tab[nacc].lane7);
            end
          end else begin
            chk("extra_result", nacc, NRES - 1);
          end
          nacc++;
        end
      end
      prev_valid = res_valid;
      prev_taken = res_valid && res_ready;
      if (in_valid && in_ready) acc_cnt++;
      if (frame_done) begin
        done_cnt++;
        chk("results_at_done", nacc, NRES);
        chk("busy_at_done", busy, 1'b0);
        break;
      end
      if (abort && nseen >= 1) begin
        hold_cnt++;
        if (hold_cnt > 2) return;
      end
      @(negedge clk);
    end
    chk("frame_done_seen", done_cnt, 1);
    chk("results_count", nacc, NRES);
    cfg_filter_we = 1'b0;
    start         = 1'b0;
    in_valid      = 1'b0;
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 1'b0);
    chk("filter_guard", win_filter, pack_taps());
`ifdef CBS_SCHED_PERF_EN
    if (rm == 1) chk("stall_cycles", stall_cycles, 32'd5);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    basic_tab[0] = '{0, 0, 1'b0, 19, 26};
    basic_tab[1] = '{0, 1, 1'b0, 27, 34};
    basic_tab[2] = '{1, 0, 1'b0, 37, 44};
    basic_tab[3] = '{1, 1, 1'b1, 45, 52};
    scen_tab[0]  = '{0, 0, 1'b0};
    scen_tab[1]  = '{0, 1, 1'b0};
    scen_tab[2]  = '{1, 0, 1'b0};
    scen_tab[3]  = '{0, 0, 1'b1};
    scen_tab[4]  = '{1, 2, 1'b1};

    start = 1'b0; cfg_filter_we = 1'b0; cfg_filter = '0;
    in_valid = 1'b0; in_pixel = '0; res_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 120'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_win_filter", win_filter, 72'd0);
    chk("rst_res_tag", {res_row, res_tile, res_last}, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < W*H; i++) pix[i] = 8'(i % 256);
    for (int t = 0; t < 9; t++) taps[t] = (t == 4) ? 8'd1 : 8'd0;
    load_filter();

    foreach (scen_tab[s]) run_frame(scen_tab[s].vm, scen_tab[s].rm, scen_tab[s].inject, 1'b1, 1'b0);

    // Async reset while EMIT waits between tile 0 and tile 1.
    run_frame(0, 3, 1'b0, 1'b0, 1'b1);
    chk("pre_reset_valid", res_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_valid", res_valid, 1'b0);
    chk("arst_res_data", res_data, 120'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_win_filter", win_filter, 72'd0);
    chk("arst_tags", {res_row, res_tile, res_last, frame_done}, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    load_filter();
    run_frame(0, 0, 1'b0, 1'b1, 1'b0);

    // Random images and filters with random input gaps and backpressure.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W*H; i++) pix[i] = 8'($urandom);
      for (int t = 0; t < 9; t++) taps[t] = 8'($urandom);
      load_filter();
      run_frame(2, 2, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cbs_tile_scheduler.md
Name: cbs_tile_scheduler

Overview:
Streaming controller that sequences the 3x3 CBS convolution strip engine across a full image.
- Accepts raster pixels through a valid/ready port into three rotating line buffers.
- Once three rows are held, issues one 3-row x 10-pixel window per tile (stride 8) to the engine together with the held 72-bit filter.
- Registers the engine's 120-bit result and presents it downstream with a row/tile tag under valid/ready.
- Sits between the frame DMA and the CBS engine instance.

Parameters:
IMG_W, 34, image width in pixels; (IMG_W-2) must be a multiple of 8, IMG_W>=10
IMG_H, 34, image height in rows; IMG_H>=3
NT (localparam), (IMG_W-2)/8, tiles per output row
ROW_W (localparam), max(1,$clog2(IMG_H)), width of the row tag
TILE_W (localparam), max(1,$clog2(NT)), width of the tile tag

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins a frame (honoured only in IDLE)
cfg_filter_we  in  1  filter write strobe (honoured only in IDLE)
cfg_filter  in  72  nine 8-bit taps, tap0 at [71:64]
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid&&in_ready
in_pixel  in  8  raster-order pixel
win_img  out  240  window to engine: [239:160] top row, [159:80] middle row, [79:0] newest row; leftmost pixel in the MSB byte of each row slice
win_filter  out  72  held filter to engine
conv_result  in  120  combinational engine result for win_img
res_valid  out  1  result valid
res_ready  in  1  downstream accept
res_data  out  120  registered conv_result
res_row  out  ROW_W  output row index, 0..IMG_H-3
res_tile  out  TILE_W  tile index, 0..NT-1
res_last  out  1  final result of the frame
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset value of every register and output is 0: state=IDLE, filter, counters, row pointer, res_*, frame_done. Line-buffer contents are don't-care.
- A reset asserted mid-frame aborts the frame. No partial result remains valid.
- IDLE:
  - cfg_filter_we loads the filter register; win_filter is driven from it.
  - start moves to FILL and clears col, row and out_row counters.
  - in_ready=0.
- FILL:
  - in_ready=1. Each accepted pixel is written to buffer[wptr][col]; col increments.
  - At col=IMG_W-1 with acceptance: col wraps to 0, row increments, wptr rotates mod 3.
  - If fewer than 3 rows are loaded, stay in FILL. Otherwise go to EMIT with tile=0.
- EMIT:
  - in_ready=0 (input stalls).
  - win_img is a combinational mux of the three buffers: oldest, middle, then newest row; pixels 8*tile..8*tile+9.
  - Issue condition: !res_valid || res_ready.
  - On issue:
    - res_data<=conv_result, res_row<=out_row, res_tile<=tile, res_valid<=1.
    - res_last<=1 when out_row=IMG_H-3 and tile=NT-1.
    - tile increments.
  - Latency: result visible 1 cycle after issue. Full throughput is 1 tile/cycle when res_ready is held high.
- After issuing tile NT-1:
  - If out_row=IMG_H-3, go to DONE.
  - Otherwise out_row increments and the state returns to FILL, which loads exactly one more row.
- res_valid clears on res_ready when no new issue occurs in the same cycle.
- Simultaneous res_ready and a new issue: the register is replaced with no bubble.
- DONE:
  - Waits until the last result has been accepted (!res_valid).
  - Then frame_done=1 for one cycle and the state returns to IDLE.
- Ignored inputs:
  - start outside IDLE.
  - cfg_filter_we outside IDLE.
  - in_pixel while in_ready=0.
- Zero-padding is not performed. The frame yields (IMG_H-2)*NT results.

Optional Feature:
CBS_SCHED_PERF_EN
- Defined:
  - Adds output stall_cycles[31:0]. It counts cycles with res_valid && !res_ready, saturates at all-ones, clears on accepted start, resets to 0.
  - Adds output in_stall_cycles[31:0]. It counts cycles with in_valid && !in_ready while busy, using the same rules.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Shared package cbs_pkg holds:
  - PIX_W=8, TAPS=9, WIN_COLS=10, WIN_ROWS=3, LANES=8, RES_W=120.
  - State enum sched_state_t {IDLE, FILL, EMIT, DONE}.
- One natural sub-module is cbs_line_buf3: three IMG_W x 8 buffers, write port, rotating pointer, and the 240-bit window read mux. The FSM stays in cbs_tile_scheduler.

Test Plan:
All scenarios use IMG_W=18, IMG_H=4 (NT=2, 4 results/frame), pixel(r,c) = (r*18+c) mod 256, filter = centre tap 1, others 0.
- Basic frame, res_ready=1: results in order (row,tile) = (0,0),(0,1),(1,0),(1,1). Lane k of each result equals pixel(row+1, 8*tile+k+1); for row0/tile0, lane0 = 19 and lane7 = 26. res_last only on the 4th result, frame_done one cycle after it.
- Backpressure: hold res_ready=0 for 5 cycles on the first result -> res_data stable and no tile skipped; with CBS_SCHED_PERF_EN, stall_cycles=5.
- Input gaps: in_valid toggles every other cycle -> results identical to the basic frame; in_ready=0 throughout EMIT.
- Config guard: cfg_filter_we with all-ones while busy -> filter unchanged, results unchanged. Start pulse mid-frame is ignored.
- Async reset asserted mid-EMIT (between tiles) -> all outputs 0 immediately, state IDLE. A fresh start then reproduces the basic frame exactly.
